// File: rtl/reg_file_ctrl_pkg.sv
// reg_file_ctrl_pkg
// Shared widths, the controller FSM state type and the requester id type
// used by the register-file sequencing controller, its arbiter and its bus
// interface.
package reg_file_ctrl_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 14;

    // Highest implemented address, sized to the address bus so that the
    // range check and the clear counter compare at matching widths.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLEAR = 3'd4
    } ctrl_state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/reg_file_ctrl_if.sv
// reg_file_ctrl_if
// Bundles every non-clock/reset signal of the controller:
//   a_req_* / a_rsp_*  requester A valid/ready request and response pulse
//   b_req_* / b_rsp_*  requester B, same set
//   clr_*              clear-sweep start pulse, busy level, done pulse
//   rf_*               single register-file port (registered read data)
// modport slave  : the controller side
// modport master : the requesters / register file side
interface reg_file_ctrl_if;
    import reg_file_ctrl_pkg::*;

    logic              a_req_valid;
    logic              a_req_ready;
    logic              a_req_we;
    logic [ADDR_W-1:0] a_req_addr;
    logic [DATA_W-1:0] a_req_wdata;
    logic              a_rsp_valid;
    logic              a_rsp_err;
    logic [DATA_W-1:0] a_rsp_rdata;

    logic              b_req_valid;
    logic              b_req_ready;
    logic              b_req_we;
    logic [ADDR_W-1:0] b_req_addr;
    logic [DATA_W-1:0] b_req_wdata;
    logic              b_rsp_valid;
    logic              b_rsp_err;
    logic [DATA_W-1:0] b_rsp_rdata;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic              rf_write_en;
    logic              rf_read_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data_in;
    logic [DATA_W-1:0] rf_data_out;

    modport slave (
        input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
        input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
        input  clr_start, rf_data_out,
        output a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata,
        output b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata,
        output clr_busy, clr_done,
        output rf_write_en, rf_read_en, rf_addr, rf_data_in
    );

    modport master (
        output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
        output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
        output clr_start, rf_data_out,
        input  a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata,
        input  b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata,
        input  clr_busy, clr_done,
        input  rf_write_en, rf_read_en, rf_addr, rf_data_in
    );

endinterface

// File: rtl/reg_file_ctrl_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter.
//   clk, rst   clock, asynchronous active-low reset
//   req[1:0]   request vector (bit 0 = A, bit 1 = B)
//   advance    a grant was taken this cycle; remember who won
//   grant[1:0] one-hot grant, combinational from req and the last winner
module rr_arbiter2
    import reg_file_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 = B won the last contention; reset value makes A win first.
    logic last_b_q, last_b_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_b_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_b_d = last_b_q;
        if (advance) begin
            last_b_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
// Sequencing controller in front of a 16-bit x 14-entry register file.
// Arbitrates two valid/ready requesters round-robin onto the single rf port,
// rejects addresses beyond the last register with an error response, and
// runs a hardware clear sweep that writes zero to every register.
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   reg_file_ctrl_if.slave: requester A/B, clear control, rf port
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting; clr_start wins over requests, else grant + accept
// ST_ISSUE | drive the rf strobe for the accepted request
// ST_WAIT  | read only: capture the registered rf_data_out
// ST_RESP  | one-cycle response pulse to the granted requester
// ST_CLEAR | write zero to address cnt_q, one register per cycle
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    reg_file_ctrl_if.slave bus
);

    ctrl_state_e       state_q, state_d;
    req_id_t           id_q, id_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;

    logic [1:0]        grant;
    logic              advance;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.b_req_valid, bus.a_req_valid}),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        we_d            = we_q;
        err_d           = err_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        cnt_d           = cnt_q;
        clr_done_d      = 1'b0;
        advance         = 1'b0;

        bus.a_req_ready = 1'b0;
        bus.b_req_ready = 1'b0;
        bus.a_rsp_valid = 1'b0;
        bus.a_rsp_err   = 1'b0;
        bus.a_rsp_rdata = '0;
        bus.b_rsp_valid = 1'b0;
        bus.b_rsp_err   = 1'b0;
        bus.b_rsp_rdata = '0;
        bus.clr_busy    = 1'b0;
        bus.rf_write_en = 1'b0;
        bus.rf_read_en  = 1'b0;
        bus.rf_addr     = '0;
        bus.rf_data_in  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end else if (grant != 2'b00) begin
                    advance         = 1'b1;
                    bus.a_req_ready = grant[0];
                    bus.b_req_ready = grant[1];
                    if (grant[1]) begin
                        id_d = REQ_B;
                    end else begin
                        id_d = REQ_A;
                    end
                    we_d    = grant[1] ? bus.b_req_we    : bus.a_req_we;
                    addr_d  = grant[1] ? bus.b_req_addr  : bus.a_req_addr;
                    wdata_d = grant[1] ? bus.b_req_wdata : bus.a_req_wdata;
                    // Cleared here so writes and errors answer with zero data.
                    rdata_d = '0;
                    err_d   = (addr_d > LAST_ADDR);
                    state_d = err_d ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.rf_addr = addr_q;
                if (we_q) begin
                    bus.rf_write_en = 1'b1;
                    bus.rf_data_in  = wdata_q;
                    state_d         = ST_RESP;
                end else begin
                    bus.rf_read_en = 1'b1;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdata_d = bus.rf_data_out;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (id_q == REQ_B) begin
                    bus.b_rsp_valid = 1'b1;
                    bus.b_rsp_err   = err_q;
                    bus.b_rsp_rdata = rdata_q;
                end else begin
                    bus.a_rsp_valid = 1'b1;
                    bus.a_rsp_err   = err_q;
                    bus.a_rsp_rdata = rdata_q;
                end
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                bus.clr_busy    = 1'b1;
                bus.rf_write_en = 1'b1;
                bus.rf_addr     = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    clr_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Done is registered so it lands in the first IDLE cycle after the sweep.
    assign bus.clr_done = clr_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            id_q       <= REQ_A;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl
// Directed bench for reg_file_ctrl with a transaction-timeline reference
// model: each accepted request or clear is expanded into the outputs
// expected on later cycles, and every cycle is compared against that
// schedule. A behavioural register file answers the rf port.
module tb_reg_file_ctrl;
    import reg_file_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    reg_file_ctrl_if bus ();

    reg_file_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: registered read, data valid the cycle after read_en.
    logic [DATA_W-1:0] rf_mem [16] = '{default: 16'h5A5A};
    always @(posedge clk) begin
        if (bus.rf_write_en) rf_mem[bus.rf_addr] <= bus.rf_data_in;
        if (bus.rf_read_en)  bus.rf_data_out <= rf_mem[bus.rf_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              we;
        logic              re;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              busy;
        logic              done;
        logic              a_v;
        logic              a_e;
        logic [DATA_W-1:0] a_d;
        logic              b_v;
        logic              b_e;
        logic [DATA_W-1:0] b_d;
    } exp_t;

    exp_t              ring [32];
    logic [DATA_W-1:0] mem_ref [16] = '{default: 16'h5A5A};
    int                next_free = 0;
    bit                last_b = 1'b1;
    int                busy_seen = 0;
    int                done_seen = 0;

    function automatic exp_t with_rsp(input exp_t x, input bit to_b, input bit err, input logic [DATA_W-1:0] d);
        exp_t y = x;
        if (to_b) begin y.b_v = 1'b1; y.b_e = err; y.b_d = d; end
        else      begin y.a_v = 1'b1; y.a_e = err; y.a_d = d; end
        return y;
    endfunction

    always @(negedge clk) begin
        exp_t              e;
        bit                exp_ar, exp_br, gb, r_we;
        logic [ADDR_W-1:0] r_addr;
        logic [DATA_W-1:0] r_wd;
        int                s;
        exp_ar = 1'b0;
        exp_br = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 32; i++) ring[i] = '0;
            last_b    = 1'b1;
            next_free = cyc + 1;
        end else if (cyc >= next_free) begin
            if (bus.clr_start) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    s = (cyc + 1 + k) % 32;
                    ring[s].we   = 1'b1;
                    ring[s].addr = ADDR_W'(k);
                    ring[s].din  = '0;
                    ring[s].busy = 1'b1;
                end
                ring[(cyc + NUM_REGS + 1) % 32].done = 1'b1;
                next_free = cyc + NUM_REGS + 1;
            end else if (bus.a_req_valid || bus.b_req_valid) begin
                gb     = (bus.a_req_valid && bus.b_req_valid) ? !last_b : bus.b_req_valid;
                last_b = gb;
                exp_ar = !gb;
                exp_br = gb;
                r_we   = gb ? bus.b_req_we    : bus.a_req_we;
                r_addr = gb ? bus.b_req_addr  : bus.a_req_addr;
                r_wd   = gb ? bus.b_req_wdata : bus.a_req_wdata;
                if (int'(r_addr) >= NUM_REGS) begin
                    s = (cyc + 1) % 32;
                    ring[s] = with_rsp(ring[s], gb, 1'b1, '0);
                    next_free = cyc + 2;
                end else if (r_we) begin
                    s = (cyc + 1) % 32;
                    ring[s].we   = 1'b1;
                    ring[s].addr = r_addr;
                    ring[s].din  = r_wd;
                    s = (cyc + 2) % 32;
                    ring[s] = with_rsp(ring[s], gb, 1'b0, '0);
                    next_free = cyc + 3;
                end else begin
                    s = (cyc + 1) % 32;
                    ring[s].re   = 1'b1;
                    ring[s].addr = r_addr;
                    s = (cyc + 3) % 32;
                    ring[s] = with_rsp(ring[s], gb, 1'b0, mem_ref[r_addr]);
                    next_free = cyc + 4;
                end
            end
        end
        e = ring[cyc % 32];
        chk("a_req_ready", bus.a_req_ready, exp_ar);
        chk("b_req_ready", bus.b_req_ready, exp_br);
        chk("rf_write_en", bus.rf_write_en, e.we);
        chk("rf_read_en",  bus.rf_read_en,  e.re);
        chk("rf_addr",     bus.rf_addr,     e.addr);
        chk("rf_data_in",  bus.rf_data_in,  e.din);
        chk("clr_busy",    bus.clr_busy,    e.busy);
        chk("clr_done",    bus.clr_done,    e.done);
        chk("a_rsp_valid", bus.a_rsp_valid, e.a_v);
        chk("a_rsp_err",   bus.a_rsp_err,   e.a_e);
        chk("a_rsp_rdata", bus.a_rsp_rdata, e.a_d);
        chk("b_rsp_valid", bus.b_rsp_valid, e.b_v);
        chk("b_rsp_err",   bus.b_rsp_err,   e.b_e);
        chk("b_rsp_rdata", bus.b_rsp_rdata, e.b_d);
        if (rst && e.we) mem_ref[e.addr] = e.din;
        ring[cyc % 32] = '0;
        if (bus.clr_busy) busy_seen++;
        if (bus.clr_done) done_seen++;
    end

    // ---------------- stimulus ----------------
    int t_last  = -1;
    int clr_cyc = -1;

    task automatic do_req(input bit is_b, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input bit with_clr);
        bit got;
        got    = 1'b0;
        t_last = -1;
        @(posedge clk); #1;
        if (is_b) begin
            bus.b_req_valid = 1'b1; bus.b_req_we = we; bus.b_req_addr = addr; bus.b_req_wdata = wd;
        end else begin
            bus.a_req_valid = 1'b1; bus.a_req_we = we; bus.a_req_addr = addr; bus.a_req_wdata = wd;
        end
        bus.clr_start = with_clr;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (n == 0) clr_cyc = cyc;
            if ((is_b && bus.b_req_ready) || (!is_b && bus.a_req_ready)) begin
                got    = 1'b1;
                t_last = cyc;
            end
            @(posedge clk); #1;
            bus.clr_start = 1'b0;
        end
        // Scramble the fields after the handshake; the DUT must have latched them.
        bus.a_req_valid = 1'b0; bus.a_req_addr = ~addr; bus.a_req_wdata = ~wd;
        bus.b_req_valid = 1'b0; bus.b_req_addr = ~addr; bus.b_req_wdata = ~wd;
        chk("handshake_seen", got, 1);
    endtask

    task automatic rd_chk(input bit is_b, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] exp, input bit with_clr);
        do_req(is_b, 1'b0, addr, 16'h0000, with_clr);
        repeat (3) @(negedge clk);
        if (is_b) begin
            chk("rd_b_valid", bus.b_rsp_valid, 1);
            chk("rd_b_data",  bus.b_rsp_rdata, exp);
            chk("rd_a_quiet", bus.a_rsp_valid, 0);
        end else begin
            chk("rd_a_valid", bus.a_rsp_valid, 1);
            chk("rd_a_data",  bus.a_rsp_rdata, exp);
            chk("rd_b_quiet", bus.b_rsp_valid, 0);
        end
    endtask

    task automatic contend(input int n, output logic [7:0] ord, output int ng);
        ord = '0;
        ng  = 0;
        @(posedge clk); #1;
        bus.a_req_valid = 1'b1; bus.a_req_we = 1'b0; bus.a_req_addr = 4'd1;
        bus.b_req_valid = 1'b1; bus.b_req_we = 1'b0; bus.b_req_addr = 4'd2;
        for (int k = 0; k < 80 && ng < n; k++) begin
            @(negedge clk);
            if (bus.a_req_ready) begin ord[ng] = 1'b0; ng++; end
            else if (bus.b_req_ready) begin ord[ng] = 1'b1; ng++; end
            @(posedge clk); #1;
        end
        bus.a_req_valid = 1'b0;
        bus.b_req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ord;
        int         ng, d0, b0;
        rst = 1'b1;
        bus.a_req_valid = 1'b0; bus.a_req_we = 1'b0; bus.a_req_addr = '0; bus.a_req_wdata = '0;
        bus.b_req_valid = 1'b0; bus.b_req_we = 1'b0; bus.b_req_addr = '0; bus.b_req_wdata = '0;
        bus.clr_start   = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_a_rdata", bus.a_rsp_rdata, 0);
        chk("rst_rf_addr", bus.rf_addr, 0);
        chk("rst_busy",    bus.clr_busy, 0);
        chk("rst_done",    bus.clr_done, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // A writes 0xAAAA to 3; B seeds 1 and 2, then reads 3.
        do_req(1'b0, 1'b1, 4'd3, 16'hAAAA, 1'b0);
        @(negedge clk);
        chk("wr_rf_we",   bus.rf_write_en, 1);
        chk("wr_rf_addr", bus.rf_addr, 3);
        chk("wr_rf_din",  bus.rf_data_in, 16'hAAAA);
        @(negedge clk);
        chk("wr_a_rsp",   bus.a_rsp_valid, 1);
        chk("wr_a_err",   bus.a_rsp_err, 0);
        chk("wr_b_quiet", bus.b_rsp_valid, 0);
        do_req(1'b1, 1'b1, 4'd1, 16'h1001, 1'b0);
        do_req(1'b1, 1'b1, 4'd2, 16'h2002, 1'b0);
        rd_chk(1'b1, 4'd3, 16'hAAAA, 1'b0);

        // Contention: last winner was B, so A, B, A, B.
        contend(4, ord, ng);
        chk("rr_count", ng, 4);
        chk("rr_order", ord[3:0], 4'b1010);

        // Invalid address.
        do_req(1'b0, 1'b0, 4'd15, 16'h0000, 1'b0);
        @(negedge clk);
        chk("inv_valid", bus.a_rsp_valid, 1);
        chk("inv_err",   bus.a_rsp_err, 1);
        chk("inv_rdata", bus.a_rsp_rdata, 0);
        chk("inv_no_re", bus.rf_read_en, 0);

        // Fill, clear with a read held during the sweep, read everything back.
        for (int i = 0; i < NUM_REGS; i++) begin
            do_req(1'b0, 1'b1, ADDR_W'(i), 16'(16'hAAAA + i), 1'b0);
        end
        repeat (4) @(posedge clk);
        b0 = busy_seen;
        d0 = done_seen;
        rd_chk(1'b0, 4'd13, 16'h0000, 1'b1);
        chk("clr_accept_delay", t_last - clr_cyc, 15);
        chk("clr_busy_cycles",  busy_seen - b0, 14);
        chk("clr_done_pulses",  done_seen - d0, 1);
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            rd_chk(i[0], ADDR_W'(i), 16'h0000, 1'b0);
        end

        // Clear and a write request in the same IDLE cycle.
        do_req(1'b0, 1'b1, 4'd7, 16'h1234, 1'b1);
        chk("prio_accept_delay", t_last - clr_cyc, 15);
        rd_chk(1'b1, 4'd7, 16'h1234, 1'b0);

        // Reset during the WAIT cycle of a read (A won last).
        do_req(1'b0, 1'b0, 4'd5, 16'h0000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("midrd_a_rsp", bus.a_rsp_valid, 0);
        chk("midrd_re",    bus.rf_read_en, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrd_no_rsp", bus.a_rsp_valid, 0);
        contend(2, ord, ng);
        chk("post_rst_count", ng, 2);
        chk("post_rst_order", ord[1:0], 2'b10);

        // Reset in the middle of a clear sweep.
        d0 = done_seen;
        @(posedge clk); #1 bus.clr_start = 1'b1;
        @(posedge clk); #1 bus.clr_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("sweep_busy_pre", bus.clr_busy, 1);
        rst = 1'b0; #1;
        chk("sweep_busy_rst", bus.clr_busy, 0);
        chk("sweep_we_rst",   bus.rf_write_en, 0);
        chk("sweep_addr_rst", bus.rf_addr, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("sweep_no_done", done_seen - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
